// File: rtl/host_direct_executor.sv
// HostDirect command executor: turns immediate host read/write commands into one or two
// single-beat 512-bit AXI transactions and returns a completion with the command ID.
package host_direct_pkg;

    localparam int unsigned AxiIdWidth = 6;

    typedef struct packed {
        logic         nic_to_host;
        logic [63:0]  host_addr;
        logic [31:0]  imm_data_size;
        logic [511:0] imm_data;
    } host_direct_cmd_t;

    typedef struct packed {
        host_direct_cmd_t host_direct_cmd;
    } pspin_cmd_descr_t;

    typedef struct packed {
        logic [7:0]       cmd_id;
        logic             generate_event;
        pspin_cmd_descr_t descr;
    } pspin_cmd_t;

    typedef struct packed {
        logic [7:0]   cmd_id;
        logic [511:0] imm_data;
    } pspin_cmd_resp_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [63:0]           addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [0:0]            user;
    } axi_aw_t;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  strb;
        logic         last;
        logic [0:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [1:0]            resp;
        logic [0:0]            user;
    } axi_b_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [63:0]           addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [0:0]            user;
    } axi_ar_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [511:0]          data;
        logic [1:0]            resp;
        logic                  last;
        logic [0:0]            user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } host_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } host_resp_t;

endpackage

module host_direct_executor
    import host_direct_pkg::*;
#(
    parameter logic [AxiIdWidth-1:0] AXI_ID = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  pspin_cmd_t      cmd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output pspin_cmd_resp_t resp_o,
    output host_req_t       host_req_o,
    input  host_resp_t      host_resp_i,
    output logic [31:0]     err_cnt_o
);

    typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StResp} state_e;

    state_e       state_q;
    logic [7:0]   cmd_id_q;
    logic         gen_event_q;
    logic         is_write_q;
    logic         beat_q;
    logic         aw_done_q;
    logic         w_done_q;
    logic [57:0]  line_q;
    logic [5:0]   off_q;
    logic [6:0]   size_q;
    logic [511:0] imm_q;
    logic [511:0] result_q;
    logic [31:0]  err_cnt_q;

    host_direct_cmd_t hd;
    logic [6:0]   cmd_size;
    logic [6:0]   end_pos;
    logic         second_pending;
    logic [8:0]   sh0;
    logic [9:0]   sh1;
    logic [63:0]  size_mask;
    logic [63:0]  strb0;
    logic [63:0]  strb1;
    logic [511:0] byte_mask;
    logic [511:0] rd_shifted;
    logic         aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic         err_inc;

    assign hd       = cmd_i.descr.host_direct_cmd;
    assign cmd_size = (hd.imm_data_size > 32'd64) ? 7'd64 : hd.imm_data_size[6:0];

    assign end_pos        = {1'b0, off_q} + size_q;
    assign second_pending = (end_pos > 7'd64) && !beat_q;
    assign sh0            = {off_q, 3'b000};
    // Beat 1 only exists when off_q != 0, so 64 - off_q never reaches 64.
    assign sh1            = {7'd64 - {1'b0, off_q}, 3'b000};
    assign size_mask      = size_q[6] ? '1 : ((64'd1 << size_q) - 64'd1);
    assign strb0          = size_mask << off_q;
    assign strb1          = (64'd1 << (end_pos - 7'd64)) - 64'd1;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 64; i++) begin
            if (7'(i) < size_q) byte_mask[i*8 +: 8] = 8'hFF;
        end
    end

    assign rd_shifted = beat_q ? (host_resp_i.r.data << sh1) : (host_resp_i.r.data >> sh0);

    assign aw_hs   = host_req_o.aw_valid && host_resp_i.aw_ready;
    assign w_hs    = host_req_o.w_valid && host_resp_i.w_ready;
    assign b_hs    = host_req_o.b_ready && host_resp_i.b_valid;
    assign ar_hs   = host_req_o.ar_valid && host_resp_i.ar_ready;
    assign r_hs    = host_req_o.r_ready && host_resp_i.r_valid;
    assign err_inc = (b_hs && host_resp_i.b.resp != 2'b00) || (r_hs && host_resp_i.r.resp != 2'b00);

    always_comb begin
        host_req_o          = '0;
        host_req_o.aw.id    = AXI_ID;
        host_req_o.aw.addr  = {line_q + 58'(beat_q), 6'b0};
        host_req_o.aw.size  = 3'd6;
        host_req_o.aw.burst = 2'b01;
        host_req_o.ar.id    = AXI_ID;
        host_req_o.ar.addr  = {line_q + 58'(beat_q), 6'b0};
        host_req_o.ar.size  = 3'd6;
        host_req_o.ar.burst = 2'b01;
        host_req_o.w.data   = beat_q ? (imm_q >> sh1) : (imm_q << sh0);
        host_req_o.w.strb   = beat_q ? strb1 : strb0;
        host_req_o.w.last   = 1'b1;
        host_req_o.aw_valid = (state_q == StWrAwW) && !aw_done_q;
        host_req_o.w_valid  = (state_q == StWrAwW) && !w_done_q;
        host_req_o.b_ready  = (state_q == StWrB);
        host_req_o.ar_valid = (state_q == StRdAr);
        host_req_o.r_ready  = (state_q == StRdR);
    end

    assign cmd_ready_o  = (state_q == StIdle) && !rst_i;
    assign resp_valid_o = (state_q == StResp);
    assign resp_o       = (state_q == StResp) ? {cmd_id_q, result_q} : '0;
    assign err_cnt_o    = err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cmd_id_q    <= '0;
            gen_event_q <= 1'b0;
            is_write_q  <= 1'b0;
            beat_q      <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            line_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (err_inc && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
            case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        cmd_id_q    <= cmd_i.cmd_id;
                        gen_event_q <= cmd_i.generate_event;
                        is_write_q  <= hd.nic_to_host;
                        line_q      <= hd.host_addr[63:6];
                        off_q       <= hd.host_addr[5:0];
                        size_q      <= cmd_size;
                        imm_q       <= hd.imm_data;
                        result_q    <= '0;
                        beat_q      <= 1'b0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        if (cmd_size == 7'd0) begin
                            state_q <= (!hd.nic_to_host || cmd_i.generate_event) ? StResp : StIdle;
                        end else begin
                            state_q <= hd.nic_to_host ? StWrAwW : StRdAr;
                        end
                    end
                end
                StWrAwW: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs) w_done_q <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= StWrB;
                    end
                end
                StWrB: begin
                    if (host_resp_i.b_valid) begin
                        if (second_pending) begin
                            beat_q  <= 1'b1;
                            state_q <= StWrAwW;
                        end else begin
                            state_q <= gen_event_q ? StResp : StIdle;
                        end
                    end
                end
                StRdAr: begin
                    if (host_resp_i.ar_ready) state_q <= StRdR;
                end
                StRdR: begin
                    if (host_resp_i.r_valid) begin
                        result_q <= (result_q | rd_shifted) & byte_mask;
                        if (second_pending) begin
                            beat_q  <= 1'b1;
                            state_q <= StRdAr;
                        end else begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (resp_ready_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic unused_resp_fields;
    assign unused_resp_fields = ^{host_resp_i.b.id, host_resp_i.b.user, host_resp_i.r.id,
                                  host_resp_i.r.last, host_resp_i.r.user, is_write_q};

endmodule
